// File: rtl/cxu_l2_arb2.sv
// Two-to-one CXU-LI L2 arbiter: round-robin grant, held while a request stalls, in-order response routing.
// Define CXU_ARB_STATS_EN to add saturating grant and full-cycle counters.
module cxu_l2_arb2 #(
  parameter int CXU_LI_VERSION = 'h01_00_00,
  parameter int CXU_N_CXUS     = 1,
  parameter int CXU_N_STATES   = 1,
  // single-CXU / single-state builds still carry a 1-bit id field
  parameter int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
  parameter int CXU_STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1,
  parameter int CXU_FUNC_ID_W  = 10,
  parameter int CXU_INSN_W     = 32,
  parameter int CXU_DATA_W     = 32,
  parameter int OUTSTANDING    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
`ifdef CXU_ARB_STATS_EN
  output logic [31:0]               stat_a_grants,
  output logic [31:0]               stat_b_grants,
  output logic [31:0]               stat_full_cycles,
`endif
  input  logic                      a_req_valid,
  output logic                      a_req_ready,
  input  logic [CXU_CXU_ID_W-1:0]   a_req_cxu,
  input  logic [CXU_STATE_ID_W-1:0] a_req_state,
  input  logic [CXU_FUNC_ID_W-1:0]  a_req_func,
  input  logic [CXU_INSN_W-1:0]     a_req_insn,
  input  logic [CXU_DATA_W-1:0]     a_req_data0,
  input  logic [CXU_DATA_W-1:0]     a_req_data1,
  output logic                      a_resp_valid,
  input  logic                      a_resp_ready,
  output logic [2:0]                a_resp_status,
  output logic [CXU_DATA_W-1:0]     a_resp_data,
  input  logic                      b_req_valid,
  output logic                      b_req_ready,
  input  logic [CXU_CXU_ID_W-1:0]   b_req_cxu,
  input  logic [CXU_STATE_ID_W-1:0] b_req_state,
  input  logic [CXU_FUNC_ID_W-1:0]  b_req_func,
  input  logic [CXU_INSN_W-1:0]     b_req_insn,
  input  logic [CXU_DATA_W-1:0]     b_req_data0,
  input  logic [CXU_DATA_W-1:0]     b_req_data1,
  output logic                      b_resp_valid,
  input  logic                      b_resp_ready,
  output logic [2:0]                b_resp_status,
  output logic [CXU_DATA_W-1:0]     b_resp_data,
  output logic                      m_req_valid,
  input  logic                      m_req_ready,
  output logic [CXU_CXU_ID_W-1:0]   m_req_cxu,
  output logic [CXU_STATE_ID_W-1:0] m_req_state,
  output logic [CXU_FUNC_ID_W-1:0]  m_req_func,
  output logic [CXU_INSN_W-1:0]     m_req_insn,
  output logic [CXU_DATA_W-1:0]     m_req_data0,
  output logic [CXU_DATA_W-1:0]     m_req_data1,
  input  logic                      m_resp_valid,
  output logic                      m_resp_ready,
  input  logic [2:0]                m_resp_status,
  input  logic [CXU_DATA_W-1:0]     m_resp_data
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  if ((CXU_LI_VERSION >> 16) != 1) begin : g_bad_version
    $error("cxu_l2_arb2: unsupported CXU-LI version");
  end
  if (CXU_DATA_W != 32 && CXU_DATA_W != 64) begin : g_bad_data_w
    $error("cxu_l2_arb2: CXU_DATA_W must be 32 or 64");
  end
  if (OUTSTANDING < 2 || OUTSTANDING > 16 || (OUTSTANDING & (OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("cxu_l2_arb2: OUTSTANDING must be a power of two in 2..16");
  end

  logic                   prio_q, prio_d;
  logic                   lock_q, lock_d;
  logic                   lock_id_q, lock_id_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;

  logic grant;
  logic gnt_valid;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic tgt_ready;
  logic req_hs;
  logic resp_hs;

  // 0 = A, 1 = B; with no valid requester the prio side is nominally granted
  always_comb begin
    if (lock_q)                       grant = lock_id_q;
    else if (a_req_valid != b_req_valid) grant = b_req_valid;
    else                              grant = prio_q;
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  assign gnt_valid   = grant ? b_req_valid : a_req_valid;
  assign m_req_valid = gnt_valid & ~fifo_full & clk_en;
  assign a_req_ready = ~grant & m_req_ready & ~fifo_full & clk_en;
  assign b_req_ready =  grant & m_req_ready & ~fifo_full & clk_en;
  assign req_hs      = m_req_valid & m_req_ready;

  assign m_req_cxu   = grant ? b_req_cxu   : a_req_cxu;
  assign m_req_state = grant ? b_req_state : a_req_state;
  assign m_req_func  = grant ? b_req_func  : a_req_func;
  assign m_req_insn  = grant ? b_req_insn  : a_req_insn;
  assign m_req_data0 = grant ? b_req_data0 : a_req_data0;
  assign m_req_data1 = grant ? b_req_data1 : a_req_data1;

  assign tgt_ready     = fifo_head ? b_resp_ready : a_resp_ready;
  assign m_resp_ready  = tgt_ready & ~fifo_empty & clk_en;
  assign a_resp_valid  = m_resp_valid & ~fifo_head & ~fifo_empty & clk_en;
  assign b_resp_valid  = m_resp_valid &  fifo_head & ~fifo_empty & clk_en;
  assign a_resp_status = m_resp_status;
  assign b_resp_status = m_resp_status;
  assign a_resp_data   = m_resp_data;
  assign b_resp_data   = m_resp_data;
  assign resp_hs       = m_resp_valid & m_resp_ready;

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (req_hs) begin
      lock_d                        = 1'b0;
      prio_d                        = ~grant;
      fifo_d[wr_ptr_q[PTR_W-1:0]]   = grant;
      wr_ptr_d                      = wr_ptr_q + PTR_ONE;
    end else if (m_req_valid) begin
      // stalled offer: pin the grant so the m_req payload cannot switch
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (resp_hs) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

`ifdef CXU_ARB_STATS_EN
  logic [31:0] stat_a_q, stat_a_d;
  logic [31:0] stat_b_q, stat_b_d;
  logic [31:0] stat_f_q, stat_f_d;

  always_comb begin
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    stat_f_d = stat_f_q;
    if (req_hs && !grant && stat_a_q != '1) stat_a_d = stat_a_q + 32'd1;
    if (req_hs &&  grant && stat_b_q != '1) stat_b_d = stat_b_q + 32'd1;
    if (clk_en && fifo_full && (a_req_valid || b_req_valid) && stat_f_q != '1)
      stat_f_d = stat_f_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
      stat_f_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
      stat_f_q <= stat_f_d;
    end
  end

  assign stat_a_grants    = stat_a_q;
  assign stat_b_grants    = stat_b_q;
  assign stat_full_cycles = stat_f_q;
`endif

`ifndef SYNTHESIS
  resp_without_outstanding: assert property (@(posedge clk) disable iff (!rst)
    !(m_resp_valid && fifo_empty))
    else $error("cxu_l2_arb2: m_resp_valid with no outstanding request");
`endif

endmodule

// File: tb/tb_cxu_l2_arb2.sv
// Self-checking bench for cxu_l2_arb2: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_cxu_l2_arb2;
  localparam int CW = 1, SW = 1, FW = 10, IW = 32, DW = 32, OUT = 4;
  localparam logic [2:0] CXU_OK = 3'd0;

  logic clk = 1'b0;
  logic rst, clk_en;
  logic a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [CW-1:0] a_req_cxu, b_req_cxu, m_req_cxu;
  logic [SW-1:0] a_req_state, b_req_state, m_req_state;
  logic [FW-1:0] a_req_func, b_req_func, m_req_func;
  logic [IW-1:0] a_req_insn, b_req_insn, m_req_insn;
  logic [DW-1:0] a_req_data0, b_req_data0, m_req_data0;
  logic [DW-1:0] a_req_data1, b_req_data1, m_req_data1;
  logic a_resp_valid, a_resp_ready, b_resp_valid, b_resp_ready;
  logic [2:0] a_resp_status, b_resp_status, m_resp_status;
  logic [DW-1:0] a_resp_data, b_resp_data, m_resp_data;
  logic m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
`ifdef CXU_ARB_STATS_EN
  logic [31:0] stat_a_grants, stat_b_grants, stat_full_cycles;
`endif

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  bit mq[$];
  bit m_prio, m_lock, m_lock_id;
  bit a_hs, b_hs;
  int st_a, st_b, st_f;
  bit e_grant, e_full, e_empty, e_mv, e_ar, e_br, e_tgt, e_arv, e_brv, e_mrr;

  always #5 clk = ~clk;

  cxu_l2_arb2 #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
`ifdef CXU_ARB_STATS_EN
    .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_full_cycles(stat_full_cycles),
`endif
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_cxu(a_req_cxu),
    .a_req_state(a_req_state), .a_req_func(a_req_func), .a_req_insn(a_req_insn),
    .a_req_data0(a_req_data0), .a_req_data1(a_req_data1),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .a_resp_status(a_resp_status), .a_resp_data(a_resp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_cxu(b_req_cxu),
    .b_req_state(b_req_state), .b_req_func(b_req_func), .b_req_insn(b_req_insn),
    .b_req_data0(b_req_data0), .b_req_data1(b_req_data1),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .b_resp_status(b_resp_status), .b_resp_data(b_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_cxu(m_req_cxu),
    .m_req_state(m_req_state), .m_req_func(m_req_func), .m_req_insn(m_req_insn),
    .m_req_data0(m_req_data0), .m_req_data1(m_req_data1),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_status(m_resp_status), .m_resp_data(m_resp_data)
  );

  function automatic void model_eval();
    e_full  = (mq.size() == OUT);
    e_empty = (mq.size() == 0);
    if (m_lock)                          e_grant = m_lock_id;
    else if (a_req_valid && !b_req_valid) e_grant = 1'b0;
    else if (b_req_valid && !a_req_valid) e_grant = 1'b1;
    else                                 e_grant = m_prio;
    e_mv  = (e_grant ? b_req_valid : a_req_valid) && !e_full && clk_en;
    e_ar  = !e_grant && m_req_ready && !e_full && clk_en;
    e_br  =  e_grant && m_req_ready && !e_full && clk_en;
    e_tgt = e_empty ? 1'b0 : mq[0];
    e_arv = !e_empty && !e_tgt && m_resp_valid && clk_en;
    e_brv = !e_empty &&  e_tgt && m_resp_valid && clk_en;
    e_mrr = !e_empty && clk_en && (e_tgt ? b_resp_ready : a_resp_ready);
  endfunction

  function automatic void model_commit();
    a_hs = 1'b0;
    b_hs = 1'b0;
    if (!clk_en) return;
    if (e_full && (a_req_valid || b_req_valid)) st_f++;
    if (m_resp_valid && e_mrr) void'(mq.pop_front());
    if (e_mv && m_req_ready) begin
      mq.push_back(e_grant);
      m_prio = !e_grant;
      m_lock = 1'b0;
      if (e_grant) begin b_hs = 1'b1; st_b++; end
      else begin a_hs = 1'b1; st_a++; end
    end else if (e_mv) begin
      m_lock = 1'b1;
      m_lock_id = e_grant;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b0; clk_en = 1'b1;
    a_req_valid = 0; b_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
    a_resp_ready = 0; b_resp_ready = 0; m_resp_status = '0; m_resp_data = '0;
    a_req_cxu = '0; a_req_state = '0; a_req_func = '0; a_req_insn = '0; a_req_data0 = '0; a_req_data1 = '0;
    b_req_cxu = '0; b_req_state = '0; b_req_func = '0; b_req_insn = '0; b_req_data0 = '0; b_req_data1 = '0;
    mq.delete(); m_prio = 0; m_lock = 0; m_lock_id = 0; a_hs = 0; b_hs = 0;
    st_a = 0; st_b = 0; st_f = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    a_resp_ready = 1; b_resp_ready = 1;
    #1;
    n_checks++; if (m_req_valid !== 1'b0) $display("FAIL reset_m_req_valid: got %b want 0", m_req_valid); else n_pass++;
    n_checks++; if ({a_req_ready, b_req_ready} !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", {a_req_ready, b_req_ready}); else n_pass++;
    n_checks++; if ({a_resp_valid, b_resp_valid, m_resp_ready} !== 3'b000) $display("FAIL reset_resp: got %b want 000", {a_resp_valid, b_resp_valid, m_resp_ready}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single_a();
    do_reset();
    a_req_valid = 1; a_req_func = 10'd5; a_req_data0 = 32'd7; m_req_ready = 1;
    #1;
    n_checks++; if (m_req_valid !== 1'b1) $display("FAIL single_m_req_valid: got %b want 1", m_req_valid); else n_pass++;
    n_checks++; if (m_req_func !== 10'd5 || m_req_data0 !== 32'd7) $display("FAIL single_payload: got func %0d data0 %0d want 5/7", m_req_func, m_req_data0); else n_pass++;
    n_checks++; if ({a_req_ready, b_req_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {a_req_ready, b_req_ready}); else n_pass++;
    @(negedge clk);
    a_req_valid = 0; m_resp_valid = 1; m_resp_status = CXU_OK; m_resp_data = 32'd12;
    a_resp_ready = 1; b_resp_ready = 1;
    #1;
    n_checks++; if ({a_resp_valid, b_resp_valid} !== 2'b10) $display("FAIL single_resp_route: got %b want 10", {a_resp_valid, b_resp_valid}); else n_pass++;
    n_checks++; if (a_resp_data !== 32'd12 || a_resp_status !== CXU_OK) $display("FAIL single_resp_data: got %0d/%0d want 12/0", a_resp_data, a_resp_status); else n_pass++;
    n_checks++; if (m_resp_ready !== 1'b1) $display("FAIL single_m_resp_ready: got %b want 1", m_resp_ready); else n_pass++;
    @(negedge clk);
    m_resp_valid = 0;
  endtask

  task automatic test_back_to_back();
    bit g;
    do_reset();
    a_req_valid = 1; b_req_valid = 1; a_req_data0 = 32'hAAAA; b_req_data0 = 32'hBBBB;
    m_req_ready = 1; a_resp_ready = 1; b_resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2) == 1;
      m_resp_valid = (i > 0);
      m_resp_data = i;
      #1;
      n_checks++; if ({a_req_ready, b_req_ready} !== {!g, g}) $display("FAIL b2b_grant_%0d: got %b want %b", i, {a_req_ready, b_req_ready}, {!g, g}); else n_pass++;
      n_checks++; if (m_req_data0 !== (g ? 32'hBBBB : 32'hAAAA)) $display("FAIL b2b_payload_%0d: got %h", i, m_req_data0); else n_pass++;
      if (i > 0) begin
        n_checks++; if ({a_resp_valid, b_resp_valid} !== {g, !g}) $display("FAIL b2b_resp_%0d: got %b want %b", i, {a_resp_valid, b_resp_valid}, {g, !g}); else n_pass++;
      end
      @(negedge clk);
    end
    a_req_valid = 0; b_req_valid = 0; m_resp_valid = 1;
    #1;
    n_checks++; if ({a_resp_valid, b_resp_valid} !== 2'b01) $display("FAIL b2b_resp_last: got %b want 01", {a_resp_valid, b_resp_valid}); else n_pass++;
    @(negedge clk);
    m_resp_valid = 0;
  endtask

  task automatic test_stall_lock();
    do_reset();
    a_req_valid = 1; a_req_data0 = 32'h1; m_req_ready = 1;
    @(negedge clk);
    a_req_data0 = 32'h111; m_req_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) begin b_req_valid = 1; b_req_data0 = 32'h222; end
      #1;
      n_checks++; if (m_req_valid !== 1'b1 || m_req_data0 !== 32'h111) $display("FAIL stall_payload_%0d: got %b/%h want 1/111", i, m_req_valid, m_req_data0); else n_pass++;
      @(negedge clk);
    end
    m_req_ready = 1;
    #1;
    n_checks++; if ({a_req_ready, b_req_ready} !== 2'b10 || m_req_data0 !== 32'h111) $display("FAIL stall_release_a: got %b/%h want 10/111", {a_req_ready, b_req_ready}, m_req_data0); else n_pass++;
    @(negedge clk);
    a_req_valid = 0;
    #1;
    n_checks++; if ({a_req_ready, b_req_ready} !== 2'b01 || m_req_data0 !== 32'h222) $display("FAIL stall_then_b: got %b/%h want 01/222", {a_req_ready, b_req_ready}, m_req_data0); else n_pass++;
    @(negedge clk);
    b_req_valid = 0; m_req_ready = 0;
  endtask

  task automatic test_full();
    do_reset();
    a_req_valid = 1; m_req_ready = 1; a_resp_ready = 1;
    for (int i = 0; i < OUT; i++) begin
      #1;
      n_checks++; if (m_req_valid !== 1'b1 || a_req_ready !== 1'b1) $display("FAIL full_fill_%0d: got %b%b want 11", i, m_req_valid, a_req_ready); else n_pass++;
      @(negedge clk);
    end
    b_req_valid = 1;
    #1;
    n_checks++; if ({m_req_valid, a_req_ready, b_req_ready} !== 3'b000) $display("FAIL full_block: got %b want 000", {m_req_valid, a_req_ready, b_req_ready}); else n_pass++;
    @(negedge clk);
    b_req_valid = 0; m_resp_valid = 1;
    #1;
    n_checks++; if (m_req_valid !== 1'b0 || m_resp_ready !== 1'b1) $display("FAIL full_pop_same_cycle: got %b%b want 01", m_req_valid, m_resp_ready); else n_pass++;
    @(negedge clk);
    m_resp_valid = 0;
    #1;
    n_checks++; if (m_req_valid !== 1'b1 || a_req_ready !== 1'b1) $display("FAIL full_after_pop: got %b%b want 11", m_req_valid, a_req_ready); else n_pass++;
    @(negedge clk);
    m_resp_valid = 1;
    #1;
    n_checks++; if (m_req_valid !== 1'b0) $display("FAIL full_again: got %b want 0", m_req_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (m_req_valid !== 1'b1 || m_resp_ready !== 1'b1) $display("FAIL full_push_pop: got %b%b want 11", m_req_valid, m_resp_ready); else n_pass++;
    @(negedge clk);
    m_resp_valid = 0;
    #1;
    n_checks++; if (m_req_valid !== 1'b1) $display("FAIL full_count3_push: got %b want 1", m_req_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (m_req_valid !== 1'b0) $display("FAIL full_count_kept: got %b want 0", m_req_valid); else n_pass++;
    @(negedge clk);
    a_req_valid = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req_valid = 1; m_req_ready = 1; a_resp_ready = 1; b_resp_ready = 1;
    repeat (2) @(negedge clk);
    m_resp_valid = 1;
    #1;
    n_checks++; if (a_resp_valid !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", a_resp_valid); else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_checks++; if ({a_resp_valid, b_resp_valid, m_resp_ready} !== 3'b000) $display("FAIL rstmid_async_drop: got %b want 000", {a_resp_valid, b_resp_valid, m_resp_ready}); else n_pass++;
    a_req_valid = 0; m_resp_valid = 0; m_req_ready = 0;
    #1;
    n_checks++; if ({m_req_valid, a_req_ready, b_req_ready} !== 3'b000) $display("FAIL rstmid_idle: got %b want 000", {m_req_valid, a_req_ready, b_req_ready}); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    a_req_valid = 1; b_req_valid = 1; m_req_ready = 1;
    #1;
    n_checks++; if ({a_req_ready, b_req_ready} !== 2'b10) $display("FAIL rstmid_prio_a: got %b want 10", {a_req_ready, b_req_ready}); else n_pass++;
    n_checks++; if (m_resp_ready !== 1'b0) $display("FAIL rstmid_fifo_empty: got %b want 0", m_resp_ready); else n_pass++;
    @(negedge clk);
    a_req_valid = 0; b_req_valid = 0; m_req_ready = 0;
  endtask

  task automatic test_clk_en();
    do_reset();
    clk_en = 0; a_req_valid = 1; m_req_ready = 1; a_resp_ready = 1;
    #1;
    n_checks++; if ({m_req_valid, a_req_ready, b_req_ready} !== 3'b000) $display("FAIL clken_forced_low: got %b want 000", {m_req_valid, a_req_ready, b_req_ready}); else n_pass++;
    @(negedge clk);
    clk_en = 1; b_req_valid = 1;
    #1;
    n_checks++; if ({a_req_ready, b_req_ready, m_resp_ready} !== 3'b100) $display("FAIL clken_state_held: got %b want 100", {a_req_ready, b_req_ready, m_resp_ready}); else n_pass++;
    @(negedge clk);
    a_req_valid = 0; b_req_valid = 0; m_req_ready = 0;
  endtask

`ifdef CXU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    a_req_valid = 1; b_req_valid = 1; m_req_ready = 1; a_resp_ready = 1; b_resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      m_resp_valid = (i > 0);
      @(negedge clk);
    end
    b_req_valid = 0;
    @(negedge clk);
    a_req_valid = 0;
    @(negedge clk);
    m_resp_valid = 0;
    #1;
    n_checks++; if (stat_a_grants !== 32'd3 || stat_b_grants !== 32'd2) $display("FAIL stats_grants: got %0d/%0d want 3/2", stat_a_grants, stat_b_grants); else n_pass++;
    n_checks++; if (stat_full_cycles !== 32'd0) $display("FAIL stats_full: got %0d want 0", stat_full_cycles); else n_pass++;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [CW+SW+FW+IW+2*DW-1:0] got_pl, exp_pl;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (a_hs) a_req_valid = 0;
      if (b_hs) b_req_valid = 0;
      if (!a_req_valid && $urandom_range(0, 1) == 1) begin
        a_req_valid = 1; a_req_cxu = CW'($urandom); a_req_state = SW'($urandom);
        a_req_func = FW'($urandom); a_req_insn = $urandom; a_req_data0 = $urandom; a_req_data1 = $urandom;
      end
      if (!b_req_valid && $urandom_range(0, 1) == 1) begin
        b_req_valid = 1; b_req_cxu = CW'($urandom); b_req_state = SW'($urandom);
        b_req_func = FW'($urandom); b_req_insn = $urandom; b_req_data0 = $urandom; b_req_data1 = $urandom;
      end
      m_req_ready   = ($urandom_range(0, 3) != 0);
      clk_en        = ($urandom_range(0, 15) != 0);
      m_resp_valid  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      m_resp_status = 3'($urandom);
      m_resp_data   = $urandom;
      a_resp_ready  = ($urandom_range(0, 3) != 0);
      b_resp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      n_checks++; if (m_req_valid !== e_mv) $display("FAIL rand_m_req_valid @%0d: got %b want %b", cyc, m_req_valid, e_mv); else n_pass++;
      if (a_req_valid || b_req_valid || m_lock) begin
        n_checks++; if ({a_req_ready, b_req_ready} !== {e_ar, e_br}) $display("FAIL rand_req_ready @%0d: got %b want %b", cyc, {a_req_ready, b_req_ready}, {e_ar, e_br}); else n_pass++;
      end
      if (e_mv) begin
        got_pl = {m_req_cxu, m_req_state, m_req_func, m_req_insn, m_req_data0, m_req_data1};
        exp_pl = e_grant ? {b_req_cxu, b_req_state, b_req_func, b_req_insn, b_req_data0, b_req_data1}
                         : {a_req_cxu, a_req_state, a_req_func, a_req_insn, a_req_data0, a_req_data1};
        n_checks++; if (got_pl !== exp_pl) $display("FAIL rand_payload @%0d: got %h want %h", cyc, got_pl, exp_pl); else n_pass++;
      end
      n_checks++; if ({a_resp_valid, b_resp_valid} !== {e_arv, e_brv}) $display("FAIL rand_resp_valid @%0d: got %b want %b", cyc, {a_resp_valid, b_resp_valid}, {e_arv, e_brv}); else n_pass++;
      n_checks++; if (m_resp_ready !== e_mrr) $display("FAIL rand_m_resp_ready @%0d: got %b want %b", cyc, m_resp_ready, e_mrr); else n_pass++;
      if (e_arv) begin
        n_checks++; if ({a_resp_status, a_resp_data} !== {m_resp_status, m_resp_data}) $display("FAIL rand_a_resp_data @%0d: got %h", cyc, {a_resp_status, a_resp_data}); else n_pass++;
      end
      if (e_brv) begin
        n_checks++; if ({b_resp_status, b_resp_data} !== {m_resp_status, m_resp_data}) $display("FAIL rand_b_resp_data @%0d: got %h", cyc, {b_resp_status, b_resp_data}); else n_pass++;
      end
      @(posedge clk);
      model_commit();
      @(negedge clk);
    end
`ifdef CXU_ARB_STATS_EN
    #1;
    n_checks++; if (stat_a_grants !== st_a || stat_b_grants !== st_b) $display("FAIL rand_stat_grants: got %0d/%0d want %0d/%0d", stat_a_grants, stat_b_grants, st_a, st_b); else n_pass++;
    n_checks++; if (stat_full_cycles !== st_f) $display("FAIL rand_stat_full: got %0d want %0d", stat_full_cycles, st_f); else n_pass++;
`endif
    a_req_valid = 0; b_req_valid = 0; m_resp_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_stall_lock();
    test_full();
    test_reset_mid();
    test_clk_en();
`ifdef CXU_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
